pc_fetch_ctrl: RTL

PC_FETCH_CTRL -- requirements
Module: pc_fetch_ctrl

---
 rtl/pc_fetch_ctrl_if.sv | 21 ++
 rtl/pc_fetch_ctrl.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/pc_fetch_ctrl_if.sv
// Instruction-memory fetch bus between pc_fetch_ctrl (master) and instruction memory (slave).
interface pc_fetch_ctrl_if;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_ready;
    logic [15:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ready,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ready,
        output imem_rdata
    );
endinterface

// File: rtl/pc_fetch_ctrl.sv
// Fetch-stage PC sequencer: one outstanding instruction request, one-entry skid buffer,
// deferred redirect while a request is in flight, and a sticky HALT state.
//
//   state | meaning
//   FETCH | may issue a request, drain the skid buffer, or take redirect/halt
//   WAIT  | request outstanding; address and request held until imem_ready
//   HALT  | stopped, no requests; only rst leaves
module pc_fetch_ctrl #(
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall,
    input  logic            br_valid,
    input  logic            br_taken,
    input  logic [15:0]     br_target,
    input  logic            halt,
    pc_fetch_ctrl_if.master imem,
    output logic [15:0]     pc,
    output logic            if_valid,
    output logic [15:0]     if_instr,
    output logic [15:0]     if_pc_plus2,
    output logic            halted
);
    typedef enum logic [1:0] {
        FETCH = 2'd0,
        WAIT  = 2'd1,
        HALT  = 2'd2
    } state_t;

    localparam logic [15:0] PC_INIT = {RESET_PC[15:1], 1'b0};

    state_t      state_q, state_d;
    logic [15:0] pc_q, pc_d;
    logic        if_valid_q, if_valid_d;
    logic [15:0] if_instr_q, if_instr_d;
    logic [15:0] if_pc2_q, if_pc2_d;
    logic        buf_valid_q, buf_valid_d;
    logic [15:0] buf_instr_q, buf_instr_d;
    logic [15:0] buf_pc2_q, buf_pc2_d;
    logic        rd_pend_q, rd_pend_d;
    logic [15:0] rd_target_q, rd_target_d;
    logic        hl_pend_q, hl_pend_d;

    logic        redirect;
    logic        halt_go;
    logic [15:0] tgt;
    logic [15:0] pc_plus2;
    logic        req;

    assign redirect = br_valid & br_taken;
    assign halt_go  = halt & ~redirect;
    assign tgt      = {br_target[15:1], 1'b0};
    assign pc_plus2 = pc_q + 16'd2;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= FETCH;
            pc_q        <= PC_INIT;
            if_valid_q  <= 1'b0;
            if_instr_q  <= 16'h0000;
            if_pc2_q    <= 16'h0000;
            buf_valid_q <= 1'b0;
            buf_instr_q <= 16'h0000;
            buf_pc2_q   <= 16'h0000;
            rd_pend_q   <= 1'b0;
            rd_target_q <= 16'h0000;
            hl_pend_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            if_valid_q  <= if_valid_d;
            if_instr_q  <= if_instr_d;
            if_pc2_q    <= if_pc2_d;
            buf_valid_q <= buf_valid_d;
            buf_instr_q <= buf_instr_d;
            buf_pc2_q   <= buf_pc2_d;
            rd_pend_q   <= rd_pend_d;
            rd_target_q <= rd_target_d;
            hl_pend_q   <= hl_pend_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        if_valid_d  = if_valid_q;
        if_instr_d  = if_instr_q;
        if_pc2_d    = if_pc2_q;
        buf_valid_d = buf_valid_q;
        buf_instr_d = buf_instr_q;
        buf_pc2_d   = buf_pc2_q;
        rd_pend_d   = rd_pend_q;
        rd_target_d = rd_target_q;
        hl_pend_d   = hl_pend_q;

        unique case (state_q)
            FETCH: begin
                if (redirect) begin
                    pc_d        = tgt;
                    if_valid_d  = 1'b0;
                    buf_valid_d = 1'b0;
                end else if (halt_go) begin
                    state_d     = HALT;
                    if_valid_d  = 1'b0;
                    buf_valid_d = 1'b0;
                end else if (!stall) begin
                    if (buf_valid_q) begin
                        if_instr_d  = buf_instr_q;
                        if_pc2_d    = buf_pc2_q;
                        if_valid_d  = 1'b1;
                        buf_valid_d = 1'b0;
                    end else if (imem.imem_ready) begin
                        if_instr_d = imem.imem_rdata;
                        if_pc2_d   = pc_plus2;
                        if_valid_d = 1'b1;
                        pc_d       = pc_plus2;
                    end else begin
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                // The handshake must finish; redirect/halt are remembered until it does.
                if (redirect) begin
                    rd_pend_d   = 1'b1;
                    rd_target_d = tgt;
                    if_valid_d  = 1'b0;
                    hl_pend_d   = 1'b0;
                end else if (halt_go) begin
                    hl_pend_d = 1'b1;
                end
                if (imem.imem_ready) begin
                    state_d     = FETCH;
                    rd_pend_d   = 1'b0;
                    hl_pend_d   = 1'b0;
                    buf_valid_d = 1'b0;
                    if (redirect || rd_pend_q) begin
                        pc_d       = redirect ? tgt : rd_target_q;
                        if_valid_d = 1'b0;
                    end else if (halt_go || hl_pend_q) begin
                        state_d    = HALT;
                        if_valid_d = 1'b0;
                    end else if (stall) begin
                        buf_valid_d = 1'b1;
                        buf_instr_d = imem.imem_rdata;
                        buf_pc2_d   = pc_plus2;
                        pc_d        = pc_plus2;
                    end else begin
                        if_instr_d = imem.imem_rdata;
                        if_pc2_d   = pc_plus2;
                        if_valid_d = 1'b1;
                        pc_d       = pc_plus2;
                    end
                end
            end
            default: begin
            end
        endcase
    end

    always_comb begin
        req = 1'b0;
        if (!rst) begin
            unique case (state_q)
                FETCH:   req = ~stall & ~buf_valid_q;
                WAIT:    req = 1'b1;
                default: req = 1'b0;
            endcase
        end
    end

    assign imem.imem_req  = req;
    assign imem.imem_addr = pc_q;
    assign pc             = pc_q;
    assign if_valid       = if_valid_q;
    assign if_instr       = if_instr_q;
    assign if_pc_plus2    = if_pc2_q;
    assign halted         = (state_q == HALT);
endmodule
